// File: rtl/regseq_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, FSM state encoding
// and default widths.
package regseq_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int ADDR_W_DEF = 3;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_MOV = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_AND = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_XOR = 3'b111;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        EXEC   = 3'd2,
        WRITE  = 3'd3,
        VERIFY = 3'd4
    } state_t;

endpackage

// File: rtl/regseq_alu.sv
// Combinational ALU for the sequencer: opcode, operands and immediate in;
// result, carry/borrow and zero out.
module regseq_alu
    import regseq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] p,
    input  logic [DATA_W-1:0] q,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0] wide;

    // The extra top bit of the widened add/sub is the carry-out, or the borrow for SUB.
    always_comb begin
        wide  = '0;
        carry = 1'b0;
        case (op)
            OP_LDI: wide = {1'b0, imm};
            OP_MOV: wide = {1'b0, p};
            OP_ADD: begin
                wide  = {1'b0, p} + {1'b0, q};
                carry = wide[DATA_W];
            end
            OP_SUB: begin
                wide  = {1'b0, p} - {1'b0, q};
                carry = wide[DATA_W];
            end
            OP_AND: wide = {1'b0, p & q};
            OP_OR:  wide = {1'b0, p | q};
            OP_XOR: wide = {1'b0, p ^ q};
            default: wide = '0;
        endcase
        result = wide[DATA_W-1:0];
        zero   = (result == '0);
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Initiator-side sequencer for a dual-read/single-write register file.
// Optional write read-back check enabled by defining REGSEQ_READBACK_CHECK_EN.
//
//  state  | meaning
//  IDLE   | ready for an instruction; handshake latches fields and read addresses
//  READ   | register file drives operands; captured at end of cycle
//  EXEC   | ALU result registered into LD_DATA/WA, WR raised (NOP retires here)
//  WRITE  | WR high this cycle; flags committed
//  VERIFY | read back the written register and compare (check build only)
module regfile_sequencer
    import regseq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              CLRN,
    input  logic              INSTR_VALID,
    output logic              INSTR_READY,
    input  logic [2:0]        OPCODE,
    input  logic [ADDR_W-1:0] RD,
    input  logic [ADDR_W-1:0] RS,
    input  logic [ADDR_W-1:0] RT,
    input  logic [DATA_W-1:0] IMM,
    output logic [ADDR_W-1:0] RP,
    output logic [ADDR_W-1:0] RQ,
    input  logic [DATA_W-1:0] DATAP,
    input  logic [DATA_W-1:0] DATAQ,
    output logic [ADDR_W-1:0] WA,
    output logic [DATA_W-1:0] LD_DATA,
    output logic              WR,
    output logic              DONE,
    output logic              CARRY,
    output logic              ZERO,
    output logic              ERR
);

    state_t            state;
    logic [2:0]        op_r;
    logic [ADDR_W-1:0] rd_r;
    logic [DATA_W-1:0] imm_r;
    logic [DATA_W-1:0] p_r;
    logic [DATA_W-1:0] q_r;
    logic              carry_pend;
    logic              zero_pend;

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;

    regseq_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op_r),
        .p      (p_r),
        .q      (q_r),
        .imm    (imm_r),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            state       <= IDLE;
            INSTR_READY <= 1'b1;
            RP          <= '0;
            RQ          <= '0;
            WA          <= '0;
            LD_DATA     <= '0;
            WR          <= 1'b0;
            DONE        <= 1'b0;
            CARRY       <= 1'b0;
            ZERO        <= 1'b0;
            op_r        <= OP_NOP;
            rd_r        <= '0;
            imm_r       <= '0;
            p_r         <= '0;
            q_r         <= '0;
            carry_pend  <= 1'b0;
            zero_pend   <= 1'b0;
`ifdef REGSEQ_READBACK_CHECK_EN
            ERR         <= 1'b0;
`endif
        end else begin
            WR   <= 1'b0;
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (INSTR_VALID && INSTR_READY) begin
                        op_r        <= OPCODE;
                        rd_r        <= RD;
                        imm_r       <= IMM;
                        RP          <= RS;
                        RQ          <= RT;
                        INSTR_READY <= 1'b0;
                        state       <= READ;
                    end
                end
                READ: begin
                    p_r   <= DATAP;
                    q_r   <= DATAQ;
                    state <= EXEC;
                end
                EXEC: begin
                    if (op_r == OP_NOP) begin
                        DONE        <= 1'b1;
                        INSTR_READY <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        WA         <= rd_r;
                        LD_DATA    <= alu_result;
                        WR         <= 1'b1;
                        carry_pend <= alu_carry;
                        zero_pend  <= alu_zero;
                        state      <= WRITE;
                    end
                end
                WRITE: begin
                    if (op_r == OP_ADD || op_r == OP_SUB) begin
                        CARRY <= carry_pend;
                    end
                    ZERO <= zero_pend;
`ifdef REGSEQ_READBACK_CHECK_EN
                    RP    <= WA;
                    state <= VERIFY;
`else
                    DONE        <= 1'b1;
                    INSTR_READY <= 1'b1;
                    state       <= IDLE;
`endif
                end
`ifdef REGSEQ_READBACK_CHECK_EN
                VERIFY: begin
                    if (DATAP != LD_DATA) begin
                        ERR <= 1'b1;
                    end
                    DONE        <= 1'b1;
                    INSTR_READY <= 1'b1;
                    state       <= IDLE;
                end
`endif
                default: begin
                    INSTR_READY <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifndef REGSEQ_READBACK_CHECK_EN
    assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// Scoreboard bench for regfile_sequencer with a behavioural register file;
// the read-back corruption tests are built when REGSEQ_READBACK_CHECK_EN is defined.
module tb_regfile_sequencer;
    import regseq_pkg::*;

`ifdef REGSEQ_READBACK_CHECK_EN
    localparam int DONE_LAT = 5;
`else
    localparam int DONE_LAT = 4;
`endif
    localparam int NOP_LAT = 3;
    localparam int WR_LAT  = 3;

    logic       CLK = 1'b0;
    logic       CLRN;
    logic       INSTR_VALID;
    logic       INSTR_READY;
    logic [2:0] OPCODE;
    logic [2:0] RD, RS, RT;
    logic [3:0] IMM;
    logic [2:0] RP, RQ, WA;
    logic [3:0] DATAP, DATAQ, LD_DATA;
    logic       WR, DONE, CARRY, ZERO, ERR;

    regfile_sequencer dut (
        .CLK(CLK), .CLRN(CLRN), .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY),
        .OPCODE(OPCODE), .RD(RD), .RS(RS), .RT(RT), .IMM(IMM),
        .RP(RP), .RQ(RQ), .DATAP(DATAP), .DATAQ(DATAQ),
        .WA(WA), .LD_DATA(LD_DATA), .WR(WR), .DONE(DONE),
        .CARRY(CARRY), .ZERO(ZERO), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // behavioural register file (responder); corrupt_en damages writes to R7
    logic [3:0] mem [8] = '{default: 4'h0};
    logic       corrupt_en = 1'b0;
    always @(posedge CLK) if (WR) mem[WA] <= (corrupt_en && WA == 3'd7) ? (LD_DATA ^ 4'h1) : LD_DATA;
    assign DATAP = mem[RP];
    assign DATAQ = mem[RQ];

    typedef struct {
        logic       nop;
        logic [2:0] wa;
        logic [3:0] data;
        logic       carry, zero, err;
        int         acc;
        logic [3:0] old;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] ref_rf [8] = '{default: 4'h0};
    logic       exp_carry = 1'b0, exp_zero = 1'b0, exp_err = 1'b0;
    int         cyc = 0, accept_cnt = 0, push_cnt = 0;
    int         n_checks = 0, n_pass = 0;

    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) if (CLRN && INSTR_VALID && INSTR_READY) accept_cnt <= accept_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic void model(input logic [2:0] op, input logic [3:0] p, q, imm,
                                  output logic [3:0] r, output logic c, output logic upd_c);
        int s;
        r = 4'h0; c = 1'b0; upd_c = 1'b0;
        case (op)
            3'd1: r = imm;
            3'd2: r = p;
            3'd3: begin s = int'(p) + int'(q); r = 4'(s); c = (s > 15); upd_c = 1'b1; end
            3'd4: begin s = int'(p) - int'(q); r = 4'(s); c = (p < q); upd_c = 1'b1; end
            3'd5: r = p & q;
            3'd6: r = p | q;
            3'd7: r = p ^ q;
            default: r = 4'h0;
        endcase
    endfunction

    // INSTR_VALID stays high between back-to-back calls, exercising back-pressure
    task automatic issue(input logic [2:0] op, rd, rs, rt, input logic [3:0] imm);
        exp_t e; logic [3:0] r; logic c, uc; int n;
        @(negedge CLK);
        INSTR_VALID = 1'b1; OPCODE = op; RD = rd; RS = rs; RT = rt; IMM = imm;
        n = 0;
        while (!INSTR_READY && n < 20) begin @(negedge CLK); n++; end
        if (!INSTR_READY) begin
            check("accept_timeout", 32'd0, 32'd1);
            INSTR_VALID = 1'b0;
            return;
        end
        @(posedge CLK);
        model(op, ref_rf[rs], ref_rf[rt], imm, r, c, uc);
        e.nop = (op == OP_NOP); e.wa = rd; e.data = r; e.acc = cyc; e.old = ref_rf[rd];
        if (!e.nop) begin
            ref_rf[rd] = (corrupt_en && rd == 3'd7) ? (r ^ 4'h1) : r;
            exp_zero = (r == 4'h0);
            if (uc) exp_carry = c;
            if (corrupt_en && rd == 3'd7) exp_err = 1'b1;
        end
        e.carry = exp_carry; e.zero = exp_zero; e.err = exp_err;
        sb.push_back(e);
        push_cnt++;
    endtask

    task automatic drain();
        int n;
        @(negedge CLK);
        INSTR_VALID = 1'b0;
        n = 0;
        while (sb.size() > 0 && n < 20) begin @(negedge CLK); n++; end
        if (sb.size() > 0) check("drain_timeout", sb.size(), 0);
    endtask

    task automatic flush_model();
        for (int i = sb.size() - 1; i >= 0; i--) ref_rf[sb[i].wa] = sb[i].old;
        sb.delete();
        exp_carry = 1'b0; exp_zero = 1'b0; exp_err = 1'b0;
    endtask

    // monitor: pops the oldest expectation when its DONE is due
    always @(negedge CLK) begin : mon
        int age, lat;
        if (CLRN) begin
            if (sb.size() > 0) begin
                age = cyc - sb[0].acc;
                lat = sb[0].nop ? NOP_LAT : DONE_LAT;
                check("ready", INSTR_READY, age == lat);
                check("wr", WR, !sb[0].nop && age == WR_LAT);
                if (WR && age == WR_LAT) begin
                    check("wa", WA, sb[0].wa);
                    check("ld_data", LD_DATA, sb[0].data);
                end
                check("done", DONE, age == lat);
                if (age >= lat) begin
                    check("carry", CARRY, sb[0].carry);
                    check("zero", ZERO, sb[0].zero);
                    check("err", ERR, sb[0].err);
                    void'(sb.pop_front());
                end
            end else begin
                check("idle_ready", INSTR_READY, 1);
                check("idle_wr", WR, 0);
                check("idle_done", DONE, 0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n; logic [3:0] old0;
        CLRN = 1'b0; INSTR_VALID = 1'b0;
        OPCODE = 3'd0; RD = 3'd0; RS = 3'd0; RT = 3'd0; IMM = 4'h0;
        repeat (3) @(negedge CLK);
        check("rst_ready", INSTR_READY, 1);
        check("rst_rp", RP, 0);
        check("rst_rq", RQ, 0);
        check("rst_wa", WA, 0);
        check("rst_ld_data", LD_DATA, 0);
        check("rst_wr", WR, 0);
        check("rst_done", DONE, 0);
        check("rst_carry", CARRY, 0);
        check("rst_zero", ZERO, 0);
        check("rst_err", ERR, 0);
        @(posedge CLK); #2 CLRN = 1'b1;

        issue(OP_LDI, 3'd3, 3'd0, 3'd0, 4'hA);
        issue(OP_LDI, 3'd1, 3'd0, 3'd0, 4'h9);
        issue(OP_LDI, 3'd2, 3'd0, 3'd0, 4'h8);
        issue(OP_ADD, 3'd4, 3'd1, 3'd2, 4'h0);
        issue(OP_SUB, 3'd5, 3'd2, 3'd1, 4'h0);
        issue(OP_XOR, 3'd6, 3'd1, 3'd1, 4'h0);
        issue(OP_NOP, 3'd0, 3'd0, 3'd0, 4'h0);
        issue(OP_MOV, 3'd0, 3'd3, 3'd0, 4'h0);
        issue(OP_ADD, 3'd1, 3'd1, 3'd1, 4'h0);
        issue(OP_AND, 3'd2, 3'd1, 3'd2, 4'h0);
        issue(OP_OR,  3'd7, 3'd2, 3'd5, 4'h0);
        drain();
        issue(OP_SUB, 3'd3, 3'd4, 3'd4, 4'h0);
        drain();

        for (int i = 0; i < 16; i++)
            issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 6)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        drain();

        // reset while WR is high: strobe must drop at once and no write lands
        old0 = mem[0];
        issue(OP_LDI, 3'd0, 3'd0, 3'd0, ~old0);
        @(negedge CLK); INSTR_VALID = 1'b0;
        n = 0;
        while (!WR && n < 10) begin @(negedge CLK); n++; end
        check("wr_seen_before_abort", WR, 1);
        #2 CLRN = 1'b0;
        #1;
        check("abort_wr", WR, 0);
        check("abort_ready", INSTR_READY, 1);
        check("abort_done", DONE, 0);
        check("abort_ld_data", LD_DATA, 0);
        flush_model();
        @(posedge CLK); #2 CLRN = 1'b1;
        check("abort_no_write", mem[0], old0);
        issue(OP_MOV, 3'd5, 3'd0, 3'd0, 4'h0);
        issue(OP_ADD, 3'd6, 3'd0, 3'd3, 4'h0);
        drain();

`ifdef REGSEQ_READBACK_CHECK_EN
        corrupt_en = 1'b1;
        issue(OP_LDI, 3'd7, 3'd0, 3'd0, 4'h5);
        drain();
        corrupt_en = 1'b0;
        check("err_set", ERR, 1);
        issue(OP_MOV, 3'd6, 3'd3, 3'd3, 4'h0);
        drain();
        check("err_sticky", ERR, 1);
        @(posedge CLK); #2 CLRN = 1'b0;
        flush_model();
        #3 check("err_cleared", ERR, 0);
        @(posedge CLK); #2 CLRN = 1'b1;
        issue(OP_LDI, 3'd2, 3'd0, 3'd0, 4'h6);
        drain();
        check("err_clean", ERR, 0);
`endif

        repeat (2) @(negedge CLK);
        check("accept_count", accept_cnt, push_cnt);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
